// File: rtl/evt_readout_sequencer.sv
// Event readout sequencer: walks every channel FIFO in order, reads EVT_WORDS
// words from each and streams them framed by header/channel/trailer words.
module evt_readout_sequencer #(
    parameter int N_CH      = 16,
    parameter int DW        = 16,
    parameter int EVT_WORDS = 64,
    parameter int STALL_MAX = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 need_read_i,
    input  logic [N_CH-1:0]      ch_empty_i,
    output logic [N_CH-1:0]      ch_rd_en_o,
    input  logic [N_CH*DW-1:0]   ch_dout_i,
    output logic [DW-1:0]        tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic                 tx_last_o,
    output logic [15:0]          evt_tx_o,
    output logic                 busy_o,
    output logic                 err_stall_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WC_W = (EVT_WORDS > 1) ? $clog2(EVT_WORDS) : 1;
    localparam int ST_W = $clog2(STALL_MAX + 1);

    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(EVT_WORDS - 1);
    localparam logic [ST_W-1:0] ST_MAX   = ST_W'(STALL_MAX);
    localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        HDR  = 4'd1,
        CHDR = 4'd2,
        CHK  = 4'd3,
        RD   = 4'd4,
        CAP  = 4'd5,
        SEND = 4'd6,
        TRL  = 4'd7,
        DONE = 4'd8
    } state_t;

    state_t            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [WC_W-1:0]   wcnt_q;
    logic [ST_W-1:0]   stall_q;
    logic [N_CH-1:0]   ch_rd_en_q;
    logic [DW-1:0]     tx_data_q;
    logic              tx_valid_q;
    logic              tx_last_q;
    logic [15:0]       evt_tx_q;
    logic              busy_q;
    logic              err_stall_q;

    logic [ST_W-1:0]   stall_d;
    logic [CH_W-1:0]   ch_nxt_s;
    logic [DW-1:0]     ch_slice_s;

    // Framing words carry a 4-bit tag above a 12-bit payload.
    function automatic logic [DW-1:0] frame_word(input logic [3:0] tag,
                                                 input logic [11:0] payload);
        return DW'({tag, payload});
    endfunction

    assign ch_nxt_s   = ch_q + CH_W'(1);
    assign ch_slice_s = ch_dout_i[ch_q*DW +: DW];

    // Saturating stall counter next value.
    always_comb begin
        stall_d = stall_q;
        if (stall_q == ST_MAX) begin
            stall_d = stall_q;
        end else begin
            stall_d = stall_q + ST_W'(1);
        end
    end

    // Readout FSM; all outputs are driven from registers updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            wcnt_q      <= '0;
            stall_q     <= '0;
            ch_rd_en_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            evt_tx_q    <= 16'd0;
            busy_q      <= 1'b0;
            err_stall_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && need_read_i) begin
                        state_q    <= HDR;
                        busy_q     <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= frame_word(4'hA, evt_tx_q[11:0]);
                    end
                end
                HDR: begin
                    if (tx_ready_i) begin
                        state_q   <= CHDR;
                        ch_q      <= '0;
                        tx_data_q <= frame_word(4'hC, 12'h000);
                    end
                end
                CHDR: begin
                    if (tx_ready_i) begin
                        state_q    <= CHK;
                        wcnt_q     <= '0;
                        tx_valid_q <= 1'b0;
                    end
                end
                CHK: begin
                    // Wait indefinitely on an empty FIFO; the error flag only reports it.
                    if (!ch_empty_i[ch_q]) begin
                        state_q    <= RD;
                        stall_q    <= '0;
                        ch_rd_en_q <= ONE_HOT0 << ch_q;
                    end else begin
                        stall_q <= stall_d;
                        if (stall_d == ST_MAX) begin
                            err_stall_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state_q    <= CAP;
                    ch_rd_en_q <= '0;
                end
                CAP: begin
                    state_q    <= SEND;
                    tx_data_q  <= ch_slice_s;
                    tx_valid_q <= 1'b1;
                end
                SEND: begin
                    if (tx_ready_i) begin
                        if (wcnt_q < WC_LAST) begin
                            state_q    <= CHK;
                            wcnt_q     <= wcnt_q + WC_W'(1);
                            tx_valid_q <= 1'b0;
                        end else if (ch_q < CH_LAST) begin
                            state_q   <= CHDR;
                            ch_q      <= ch_nxt_s;
                            tx_data_q <= frame_word(4'hC, {4'h0, 8'(ch_nxt_s)});
                        end else begin
                            state_q   <= TRL;
                            tx_data_q <= frame_word(4'hF, evt_tx_q[11:0]);
                            tx_last_q <= 1'b1;
                        end
                    end
                end
                TRL: begin
                    if (tx_ready_i) begin
                        state_q    <= DONE;
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    evt_tx_q <= evt_tx_q + 16'd1;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    ch_rd_en_q <= '0;
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ch_rd_en_o  = ch_rd_en_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_last_o   = tx_last_q;
    assign evt_tx_o    = evt_tx_q;
    assign busy_o      = busy_q;
    assign err_stall_o = err_stall_q;

endmodule

// File: doc/evt_readout_sequencer.md
Name: evt_readout_sequencer

Overview:
- Controls the event readout side of the front-end. The rx event-counter block asserts need_read when every channel FIFO holds at least one unread event.
- This block then visits every channel FIFO in order 0..N_CH-1 and reads exactly EVT_WORDS words from each. It frames the words with header, channel and trailer words and streams them out on a valid/ready link.
- After the trailer it increments evt_tx, the readout event count that is fed back to the rx counter block.

Parameters:
- N_CH, 16, number of channel FIFOs (1..256)
- DW, 16, data word width (fixed 16 for framing)
- EVT_WORDS, 64, words per channel per event (1..4095)
- STALL_MAX, 1023, stall cycles on an empty FIFO before err_stall is set

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  allows a new event to start; sampled only in IDLE
- need_read  in  1  at least one complete event is available in every channel
- ch_empty  in  N_CH  per-channel FIFO empty flags
- ch_rd_en  out  N_CH  one-hot FIFO read strobe; read latency is 1 cycle
- ch_dout  in  N_CH*DW  concatenated FIFO outputs; channel k is bits [k*DW+DW-1 : k*DW]
- tx_data  out  DW  output word
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  downstream accepts a word
- tx_last  out  1  marks the trailer word
- evt_tx  out  16  count of completed events
- busy  out  1  state is not IDLE
- err_stall  out  1  sticky stall-timeout flag; cleared only by reset

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE; ch_rd_en=0, tx_valid=0, tx_last=0, tx_data=0, evt_tx=0, busy=0, err_stall=0.
  - Channel index, word count and stall count are 0.
  - Reset asserted mid-event aborts the event. All outputs take reset values on the next edge, and evt_tx is not incremented.
- States: IDLE, HDR, CHDR, CHK, RD, CAP, SEND, TRL, DONE.
- IDLE: when enable=1 and need_read=1, go to HDR on the next edge.
- HDR: tx_valid=1, tx_data={4'hA, evt_tx[11:0]}. Hold until tx_ready; go to CHDR with ch=0.
- CHDR: tx_data={4'hC, 4'h0, ch[7:0]}. Hold until tx_ready; go to CHK with word count=0.
- CHK: if ch_empty[ch]=0, go to RD and clear the stall count. Otherwise stay in CHK and increment the stall count.
  - The stall count saturates.
  - When it reaches STALL_MAX, err_stall is set. The block keeps waiting; there is no skip.
- RD: ch_rd_en[ch]=1 for exactly one cycle; go to CAP.
- CAP: register ch_dout slice ch into tx_data; go to SEND.
- SEND: tx_valid=1 until tx_ready. On acceptance:
  - If word count < EVT_WORDS-1: increment word count, go to CHK.
  - Else if ch < N_CH-1: increment ch, go to CHDR.
  - Else: go to TRL.
- TRL: tx_data={4'hF, evt_tx[11:0]}, tx_last=1. Hold until tx_ready; go to DONE.
- DONE: evt_tx <= evt_tx+1, wrapping from 16'hFFFF to 0; go to IDLE.
  - need_read is re-sampled in IDLE on the following cycle, which gives the rx block one cycle to update need_read.
- Handshake rules:
  - A word transfers on a cycle where tx_valid=1 and tx_ready=1.
  - tx_data and tx_last stay stable while tx_valid=1 and tx_ready=0.
  - tx_valid=0 in IDLE, CHK, RD, CAP and DONE.
- Timing and framing:
  - Each event is 2 + N_CH*(1+EVT_WORDS) words.
  - Each data word takes at least 4 cycles (CHK, RD, CAP, SEND).
  - From need_read rising in IDLE, the header is valid after 1 cycle.
- Enable and need_read:
  - enable=0 mid-event has no effect; the event completes.
  - need_read falling mid-event is ignored.
- No read is ever issued to an empty FIFO, and at most one ch_rd_en bit is high in any cycle.
- busy=1 in every state except IDLE.

Test Plan (N_CH=2, EVT_WORDS=3, STALL_MAX=8 unless stated):
- Basic event: FIFOs preloaded ch0={11,12,13}, ch1={21,22,23}; tx_ready=1; pulse need_read.
  -> Stream A000, C000, 0011, 0012, 0013, C001, 0021, 0022, 0023, F000 (tx_last=1 on F000 only); 6 rd_en pulses; evt_tx=1; busy falls.
- Backpressure: same stimulus with tx_ready toggling pseudo-randomly.
  -> Identical word sequence; tx_data stable whenever tx_valid=1 and tx_ready=0; no duplicated or dropped words.
- Empty stall: ch1 empties after 1 word and is refilled after 20 cycles.
  -> No rd_en while ch_empty[1]=1; err_stall=1 after 8 stall cycles and stays 1; event completes with correct data.
- Wrap and enable: preset evt_tx via 65535 events (or force the counter); enable=0 with need_read=1.
  -> No start. Then enable=1 -> header A FFF, trailer FFFF, evt_tx becomes 0000.
- Reset mid-event: assert reset during SEND of ch1 word 2.
  -> Next cycle: tx_valid=0, ch_rd_en=0, evt_tx=0, err_stall=0, state IDLE; a new need_read restarts with header A000.
- Back-to-back: need_read held high and FIFOs holding 3 events.
  -> Three complete frames with headers A000, A001, A002; exactly 1 idle cycle between each DONE and the next HDR.
